dcp_tx_formatter: RTL

//   Downstream stage of the debug-command units: takes one transmit request (req_tx/type_tx/dout)

---
 rtl/dcp_tx_pkg.sv | 28 ++
 rtl/hex_to_ascii.sv | 24 ++
 rtl/dcp_tx_formatter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dcp_tx_pkg.sv
// Purpose: shared definitions for the debug-command transmit formatter:
//          request type codes, ASCII constants and the formatter FSM states.
package dcp_tx_pkg;

    // Request type carried on type_tx
    typedef enum logic [1:0] {
        TX_WORD_SP = 2'b00,   // hex word followed by a space
        TX_WORD_NL = 2'b01,   // hex word followed by CR LF
        TX_CHAR    = 2'b10,   // raw character from dout[7:0]
        TX_NL      = 2'b11    // CR LF only
    } tx_type_e;

    // Formatter FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SEND     = 2'b01,
        ST_DONE     = 2'b10,
        ST_WAIT_LOW = 2'b11
    } state_e;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_a  = 8'h61;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

endpackage

// File: rtl/hex_to_ascii.sv
// Purpose: combinational conversion of one 4-bit nibble to its ASCII hex digit.
// Ports:
//   nib_i    in   4   nibble value 0..15
//   ascii_c  out  8   ASCII '0'..'9' / 'A'..'F' (or 'a'..'f' when UPPERCASE=0)
module hex_to_ascii
    import dcp_tx_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_c
);

    localparam logic [7:0] LETTER_BASE = UPPERCASE ? ASC_A : ASC_a;

    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_c = ASC_0 + 8'(nib_i);
        end else begin
            ascii_c = LETTER_BASE + 8'(4'(nib_i - 4'd10));
        end
    end

endmodule

// File: rtl/dcp_tx_formatter.sv
// Purpose: serialises one transmit request from a command handler into ASCII
//          bytes for the UART transmitter (hex word + separator, raw char, or CR LF).
// Ports:
//   clk       in   1       system clock
//   rstn      in   1       asynchronous active-low reset
//   req_tx    in   1       request level, held until ack_tx
//   type_tx   in   2       request type (see tx_type_e)
//   dout      in   DATA_W  word/char to send, sampled on acceptance
//   ack_tx    out  1       one-cycle pulse after the final byte handshake
//   byte_out  out  8       ASCII byte to the UART
//   byte_vld  out  1       byte_out valid, held until byte_rdy
//   byte_rdy  in   1       UART accepts byte_out this cycle
//   busy      out  1       request in flight (acceptance through ack_tx)
module dcp_tx_formatter
    import dcp_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          UPPERCASE = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_tx,
    input  logic [1:0]        type_tx,
    input  logic [DATA_W-1:0] dout,
    output logic              ack_tx,
    output logic [7:0]        byte_out,
    output logic              byte_vld,
    input  logic              byte_rdy,
    output logic              busy
);

    localparam int unsigned NIB   = DATA_W / 4;
    localparam int unsigned CNT_W = $clog2(NIB + 3);

    state_e              state_q, state_d;
    tx_type_e            type_q, type_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          byte_q, byte_d;
    logic                vld_q, vld_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;

    // Source of the byte being loaded: fresh request in IDLE, in-flight state otherwise
    tx_type_e            ld_type_c;
    logic [DATA_W-1:0]   ld_word_c;
    logic [CNT_W-1:0]    ld_cnt_c;
    logic [7:0]          ld_byte_c;
    logic                ld_hex_c;
    logic [7:0]          hex_c;

    // ld_cnt_c is the number of bytes still to go, including the one being loaded
    always_comb begin
        if (state_q == ST_IDLE) begin
            ld_type_c = tx_type_e'(type_tx);
            ld_word_c = dout;
            case (tx_type_e'(type_tx))
                TX_WORD_SP: ld_cnt_c = CNT_W'(NIB + 1);
                TX_WORD_NL: ld_cnt_c = CNT_W'(NIB + 2);
                TX_CHAR:    ld_cnt_c = CNT_W'(1);
                default:    ld_cnt_c = CNT_W'(2);
            endcase
        end else begin
            ld_type_c = type_q;
            ld_word_c = shift_q;
            ld_cnt_c  = cnt_q - CNT_W'(1);
        end
    end

    hex_to_ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_hex (
        .nib_i   (ld_word_c[DATA_W-1 -: 4]),
        .ascii_c (hex_c)
    );

    // Byte selection from position in the message: digits first, separator last
    always_comb begin
        ld_hex_c  = 1'b0;
        ld_byte_c = ld_word_c[7:0];
        case (ld_type_c)
            TX_WORD_SP: begin
                ld_hex_c  = (ld_cnt_c > CNT_W'(1));
                ld_byte_c = ld_hex_c ? hex_c : ASC_SP;
            end
            TX_WORD_NL: begin
                ld_hex_c  = (ld_cnt_c > CNT_W'(2));
                ld_byte_c = ld_hex_c ? hex_c :
                            (ld_cnt_c == CNT_W'(2)) ? ASC_CR : ASC_LF;
            end
            TX_CHAR: begin
                ld_byte_c = ld_word_c[7:0];
            end
            default: begin
                ld_byte_c = (ld_cnt_c == CNT_W'(2)) ? ASC_CR : ASC_LF;
            end
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        vld_d   = vld_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (req_tx) begin
                    state_d = ST_SEND;
                    type_d  = ld_type_c;
                    cnt_d   = ld_cnt_c;
                    byte_d  = ld_byte_c;
                    shift_d = ld_hex_c ? {ld_word_c[DATA_W-5:0], 4'h0} : ld_word_c;
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_SEND: begin
                if (vld_q && byte_rdy) begin
                    cnt_d = ld_cnt_c;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        vld_d   = 1'b0;
                        ack_d   = 1'b1;
                    end else begin
                        byte_d  = ld_byte_c;
                        shift_d = ld_hex_c ? {ld_word_c[DATA_W-5:0], 4'h0} : ld_word_c;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_WAIT_LOW;
                busy_d  = 1'b0;
            end
            default: begin
                // A request held high after ack must drop before it can retrigger
                if (!req_tx) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            type_q  <= TX_WORD_SP;
            shift_q <= '0;
            cnt_q   <= '0;
            byte_q  <= 8'h00;
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ack_tx   = ack_q;
    assign byte_out = byte_q;
    assign byte_vld = vld_q;
    assign busy     = busy_q;

endmodule
